// File: rtl/entropy_dec_pkg.sv
// Shared constants, FSM state type and the probability split helper for the
// Q15 boolean arithmetic decoder.
package entropy_dec_pkg;

    localparam int          EC_PROB_SHIFT = 6;
    localparam int          EC_MIN_PROB   = 4;
    localparam logic [31:0] WINDOW_INIT   = 32'h7FFF_FFFF;
    localparam logic [15:0] RNG_INIT      = 16'h8000;
    localparam int          CNT_INIT      = -15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_READY  = 2'd2,
        ST_REFILL = 2'd3
    } dec_state_e;

    // Split point v of the current range for a Q15 probability of a one.
    function automatic logic [15:0] calc_split(input logic [15:0] rng,
                                               input logic [15:0] prob);
        logic [17:0] prod;
        prod = 18'(rng[15:8]) * 18'(prob[15:EC_PROB_SHIFT]);
        return 16'(prod >> 1) + 16'(EC_MIN_PROB);
    endfunction

endpackage

// File: rtl/entropy_dec_normalize.sv
// Combinational renormalisation: shifts the post-decision range back into
// [0x8000, 0xFFFF], shifts ones into the bottom of the dif window and
// charges the shift against the bit counter.
module entropy_dec_normalize #(
    parameter int RANGE_WIDTH  = 16,
    parameter int WINDOW_WIDTH = 32,
    parameter int CNT_WIDTH    = 6
) (
    input  logic [RANGE_WIDTH-1:0]         rng_i,
    input  logic [WINDOW_WIDTH-1:0]        dif_i,
    input  logic signed [CNT_WIDTH-1:0]    cnt_i,
    output logic [RANGE_WIDTH-1:0]         rng_o,
    output logic [WINDOW_WIDTH-1:0]        dif_o,
    output logic signed [CNT_WIDTH-1:0]    cnt_o
);

    localparam int SHW = $clog2(RANGE_WIDTH);

    // Leading zeros of the range; a zero range saturates at the maximum shift.
    function automatic logic [SHW-1:0] lead_zeros(input logic [RANGE_WIDTH-1:0] value);
        logic [SHW-1:0] lz;
        lz = SHW'(RANGE_WIDTH - 1);
        for (int i = 0; i < RANGE_WIDTH; i++) begin
            if (value[i]) begin
                lz = SHW'(RANGE_WIDTH - 1 - i);
            end else begin
                lz = lz;
            end
        end
        return lz;
    endfunction

    logic [SHW-1:0] shift_s;

    // Apply the same left shift to range and window, and debit the counter.
    always_comb begin
        shift_s = lead_zeros(rng_i);
        rng_o   = rng_i << shift_s;
        dif_o   = ((dif_i + WINDOW_WIDTH'(1)) << shift_s) - WINDOW_WIDTH'(1);
        cnt_o   = cnt_i - $signed(CNT_WIDTH'(shift_s));
    end

endmodule

// File: rtl/entropy_bool_decoder.sv
// Q15 boolean arithmetic decoder. Consumes the carry-resolved byte stream,
// keeps a W-bit dif window topped up one byte per cycle, and returns one
// registered decoded bit per accepted probability request.
module entropy_bool_decoder
    import entropy_dec_pkg::*;
#(
    parameter int TOP_RANGE_WIDTH     = 16,
    parameter int TOP_WINDOW_WIDTH    = 32,
    parameter int TOP_CNT_WIDTH       = 6,
    parameter int TOP_BITSTREAM_WIDTH = 8
) (
    input  logic                            top_clk,
    input  logic                            top_reset,
    input  logic                            top_flag_first,
    input  logic [TOP_BITSTREAM_WIDTH-1:0]  in_byte,
    input  logic                            in_byte_valid,
    input  logic                            in_byte_last,
    output logic                            in_byte_ready,
    input  logic [15:0]                     in_prob,
    input  logic                            in_req_valid,
    output logic                            in_req_ready,
    output logic                            OUT_BIT,
    output logic                            OUT_BIT_VALID,
    output logic [TOP_RANGE_WIDTH-1:0]      OUT_RANGE,
    output logic [TOP_CNT_WIDTH-1:0]        OUT_CNT
);

    localparam int W  = TOP_WINDOW_WIDTH;
    localparam int SW = $clog2(W);
    localparam logic [W-1:0] DIF_INIT = W'(WINDOW_INIT >> (32 - W));
    localparam logic signed [TOP_CNT_WIDTH-1:0] CNT_START = TOP_CNT_WIDTH'(CNT_INIT);
    localparam logic signed [TOP_CNT_WIDTH-1:0] CNT_STEP  = TOP_CNT_WIDTH'(TOP_BITSTREAM_WIDTH);
    // Byte insertion position is (W - 9) - (cnt + 15); this is the constant part.
    localparam logic signed [15:0] FILL_BASE = 16'(W - 9 - 15);

    dec_state_e                         state_q;
    logic [W-1:0]                       dif_q;
    logic [TOP_RANGE_WIDTH-1:0]         rng_q;
    logic signed [TOP_CNT_WIDTH-1:0]    cnt_q;
    logic                               eos_q;
    logic                               out_bit_q;
    logic                               out_valid_q;

    logic                               filling_s;
    logic signed [15:0]                 cnt_ext_s;
    logic signed [15:0]                 fill_shift_s;
    logic                               fill_done_s;
    logic                               fill_last_s;
    logic                               fill_step_s;
    logic                               byte_ready_s;
    logic                               byte_fire_s;
    logic [TOP_BITSTREAM_WIDTH-1:0]     fill_byte_s;
    logic [W-1:0]                       fill_word_s;

    logic                               req_fire_s;
    logic [15:0]                        split_s;
    logic [W-1:0]                       split_w_s;
    logic                               dec_bit_s;
    logic [TOP_RANGE_WIDTH-1:0]         dec_rng_s;
    logic [W-1:0]                       dec_dif_s;
    logic [TOP_RANGE_WIDTH-1:0]         norm_rng_s;
    logic [W-1:0]                       norm_dif_s;
    logic signed [TOP_CNT_WIDTH-1:0]    norm_cnt_s;

    // Fill datapath: where the next byte lands and whether this step finishes the fill.
    always_comb begin
        filling_s    = (state_q == ST_FILL) || (state_q == ST_REFILL);
        cnt_ext_s    = {{(16 - TOP_CNT_WIDTH){cnt_q[TOP_CNT_WIDTH-1]}}, cnt_q};
        fill_shift_s = FILL_BASE - cnt_ext_s;
        fill_done_s  = fill_shift_s[15];
        fill_last_s  = (fill_shift_s < 16'sd8);
        byte_ready_s = filling_s && !eos_q && !fill_done_s;
        byte_fire_s  = byte_ready_s && in_byte_valid;
        // Past the end of the stream every step inserts zeros without a byte.
        fill_step_s  = filling_s && !fill_done_s && (eos_q || in_byte_valid);
        if (eos_q) begin
            fill_byte_s = {TOP_BITSTREAM_WIDTH{1'b0}};
        end else begin
            fill_byte_s = in_byte;
        end
        fill_word_s  = W'(fill_byte_s) << fill_shift_s[SW-1:0];
    end

    // Decode decision: compare the window against the scaled split point.
    always_comb begin
        req_fire_s = in_req_valid && (state_q == ST_READY);
        split_s    = calc_split(rng_q, in_prob);
        split_w_s  = {split_s, {(W - 16){1'b0}}};
        if (dif_q >= split_w_s) begin
            dec_bit_s = 1'b0;
            dec_rng_s = rng_q - split_s;
            dec_dif_s = dif_q - split_w_s;
        end else begin
            dec_bit_s = 1'b1;
            dec_rng_s = split_s;
            dec_dif_s = dif_q;
        end
    end

    entropy_dec_normalize #(
        .RANGE_WIDTH  (TOP_RANGE_WIDTH),
        .WINDOW_WIDTH (W),
        .CNT_WIDTH    (TOP_CNT_WIDTH)
    ) u_normalize (
        .rng_i (dec_rng_s),
        .dif_i (dec_dif_s),
        .cnt_i (cnt_q),
        .rng_o (norm_rng_s),
        .dif_o (norm_dif_s),
        .cnt_o (norm_cnt_s)
    );

    // Control FSM with decoder state and registered output pulse.
    always_ff @(posedge top_clk or posedge top_reset) begin
        if (top_reset) begin
            state_q     <= ST_IDLE;
            dif_q       <= {W{1'b0}};
            rng_q       <= RNG_INIT;
            cnt_q       <= {TOP_CNT_WIDTH{1'b0}};
            eos_q       <= 1'b0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            // A request accepted this cycle always produces its pulse, even on restart.
            out_valid_q <= req_fire_s;
            if (req_fire_s) begin
                out_bit_q <= dec_bit_s;
            end
            if (top_flag_first) begin
                state_q <= ST_FILL;
                dif_q   <= DIF_INIT;
                rng_q   <= RNG_INIT;
                cnt_q   <= CNT_START;
                eos_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_IDLE;
                    end
                    ST_FILL, ST_REFILL: begin
                        if (fill_done_s) begin
                            state_q <= ST_READY;
                        end else if (fill_step_s) begin
                            dif_q <= dif_q ^ fill_word_s;
                            cnt_q <= cnt_q + CNT_STEP;
                            if (byte_fire_s && in_byte_last) begin
                                eos_q <= 1'b1;
                            end
                            if (fill_last_s) begin
                                state_q <= ST_READY;
                            end
                        end
                    end
                    ST_READY: begin
                        if (req_fire_s) begin
                            rng_q <= norm_rng_s;
                            dif_q <= norm_dif_s;
                            cnt_q <= norm_cnt_s;
                            if (norm_cnt_s[TOP_CNT_WIDTH-1]) begin
                                state_q <= ST_REFILL;
                            end else begin
                                state_q <= ST_READY;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign in_byte_ready = byte_ready_s;
    assign in_req_ready  = (state_q == ST_READY);
    assign OUT_BIT       = out_bit_q;
    assign OUT_BIT_VALID = out_valid_q;
    assign OUT_RANGE     = rng_q;
    assign OUT_CNT       = cnt_q;

endmodule

// File: tb/tb_entropy_bool_decoder.sv
// Directed bench for entropy_bool_decoder plus a round trip against a
// bench-side model of the od_ec boolean encoder.
module tb_entropy_bool_decoder;

    logic        top_clk;
    logic        top_reset;
    logic        top_flag_first;
    logic [7:0]  in_byte;
    logic        in_byte_valid;
    logic        in_byte_last;
    logic        in_byte_ready;
    logic [15:0] in_prob;
    logic        in_req_valid;
    logic        in_req_ready;
    logic        OUT_BIT;
    logic        OUT_BIT_VALID;
    logic [15:0] OUT_RANGE;
    logic [5:0]  OUT_CNT;

    int checks = 0;
    int errors = 0;
    logic saw_byte_rdy;

    localparam int NBITS = 10000;

    entropy_bool_decoder dut (
        .top_clk        (top_clk),
        .top_reset      (top_reset),
        .top_flag_first (top_flag_first),
        .in_byte        (in_byte),
        .in_byte_valid  (in_byte_valid),
        .in_byte_last   (in_byte_last),
        .in_byte_ready  (in_byte_ready),
        .in_prob        (in_prob),
        .in_req_valid   (in_req_valid),
        .in_req_ready   (in_req_ready),
        .OUT_BIT        (OUT_BIT),
        .OUT_BIT_VALID  (OUT_BIT_VALID),
        .OUT_RANGE      (OUT_RANGE),
        .OUT_CNT        (OUT_CNT)
    );

    initial top_clk = 1'b0;
    always #5 top_clk = ~top_clk;

    always @(posedge top_clk) begin
        if (in_req_valid) begin
            assert (in_prob != 16'd0 && in_prob <= 16'd32767)
                else $error("illegal probability %0d driven", in_prob);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge top_clk);
        #1;
        if (in_byte_ready) saw_byte_rdy = 1'b1;
    endtask

    task automatic start_stream();
        top_flag_first = 1'b1;
        tick();
        top_flag_first = 1'b0;
    endtask

    task automatic feed(input logic [7:0] b, input logic last);
        int waited = 0;
        in_byte = b;
        in_byte_last = last;
        in_byte_valid = 1'b1;
        while (!in_byte_ready && waited < 20) begin
            tick();
            waited++;
        end
        check("byte_accept", 32'(in_byte_ready), 32'd1);
        tick();
        in_byte_valid = 1'b0;
        in_byte_last = 1'b0;
    endtask

    task automatic request(input logic [15:0] f);
        int waited = 0;
        in_prob = f;
        in_req_valid = 1'b1;
        while (!in_req_ready && waited < 20) begin
            tick();
            waited++;
        end
        check("req_accept", 32'(in_req_ready), 32'd1);
        tick();
        in_req_valid = 1'b0;
        check("bit_valid", 32'(OUT_BIT_VALID), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bit"},       32'(OUT_BIT), 32'd0);
        check({tag, "_valid"},     32'(OUT_BIT_VALID), 32'd0);
        check({tag, "_req_rdy"},   32'(in_req_ready), 32'd0);
        check({tag, "_byte_rdy"},  32'(in_byte_ready), 32'd0);
        check({tag, "_rng"},       32'(OUT_RANGE), 32'h8000);
        check({tag, "_cnt"},       32'(OUT_CNT), 32'd0);
    endtask

    function automatic int msb_of(input int unsigned x);
        int m = 0;
        for (int i = 0; i < 32; i++) if (x[i]) m = i;
        return m;
    endfunction

    // Round-trip data
    logic [15:0]  probs_q[$];
    logic         bits_q[$];
    int unsigned  pre_q[$];
    logic [7:0]   stream_q[$];

    initial begin
        longint unsigned enc_low, m64, e64, n64;
        int unsigned enc_rng, v, r, cy;
        int enc_cnt, c, s, d, bi, ri, oi, cyc, err_before;
        logic [15:0] f;
        logic b, byte_go, req_go;

        top_reset = 1'b1;
        top_flag_first = 1'b0;
        in_byte = 8'h00;
        in_byte_valid = 1'b0;
        in_byte_last = 1'b0;
        in_prob = 16'd16384;
        in_req_valid = 1'b0;
        saw_byte_rdy = 1'b0;

        // Reset state
        tick(); tick(); tick();
        check_reset_outputs("rst_held");
        top_reset = 1'b0;
        tick();
        check_reset_outputs("rst_idle");

        // Init with 00,00,00 then f=16384
        start_stream();
        check("fill_byte_rdy", 32'(in_byte_ready), 32'd1);
        check("fill_req_rdy", 32'(in_req_ready), 32'd0);
        check("fill_cnt_init", 32'(OUT_CNT), 32'h31);
        feed(8'h00, 1'b0); feed(8'h00, 1'b0); feed(8'h00, 1'b0);
        check("z_ready", 32'(in_req_ready), 32'd1);
        check("z_cnt", 32'(OUT_CNT), 32'd9);
        check("z_dif", dut.dif_q, 32'h7FFF_FFFF);
        check("z_byte_rdy", 32'(in_byte_ready), 32'd0);
        request(16'd16384);
        check("z_bit", 32'(OUT_BIT), 32'd0);
        check("z_rng", 32'(OUT_RANGE), 32'hFFF0);
        check("z_cnt2", 32'(OUT_CNT), 32'd7);
        check("z_dif2", dut.dif_q, 32'hFFEF_FFFF);
        tick();
        check("z_pulse_once", 32'(OUT_BIT_VALID), 32'd0);

        // Init with FF,FF,FF then f=16384
        start_stream();
        feed(8'hFF, 1'b0); feed(8'hFF, 1'b0); feed(8'hFF, 1'b0);
        check("f_dif", dut.dif_q, 32'h0000_007F);
        request(16'd16384);
        check("f_bit", 32'(OUT_BIT), 32'd1);
        check("f_rng", 32'(OUT_RANGE), 32'h8008);
        check("f_cnt", 32'(OUT_CNT), 32'd8);
        check("f_dif2", dut.dif_q, 32'h0000_00FF);

        // Stream end on 2nd init byte
        start_stream();
        feed(8'h00, 1'b0);
        feed(8'h00, 1'b1);
        check("eos_byte_rdy", 32'(in_byte_ready), 32'd0);
        saw_byte_rdy = 1'b0;
        tick();
        check("eos_ready", 32'(in_req_ready), 32'd1);
        check("eos_cnt", 32'(OUT_CNT), 32'd9);
        request(16'd16384);
        check("eos_bit1", 32'(OUT_BIT), 32'd0);
        request(16'd32704);
        check("eos_rng2", 32'(OUT_RANGE), 32'hB600);
        check("eos_cnt2", 32'(OUT_CNT), 32'd0);
        request(16'd32704);
        check("eos_rng3", 32'(OUT_RANGE), 32'hAE00);
        check("eos_cnt3", 32'(OUT_CNT), 32'h37);
        request(16'd16384);
        check("eos_bit4", 32'(OUT_BIT), 32'd0);
        check("eos_rng4", 32'(OUT_RANGE), 32'hADF8);
        check("eos_cnt4", 32'(OUT_CNT), 32'd14);
        check("eos_no_byte_rdy", 32'(saw_byte_rdy), 32'd0);

        // Refill stall with the byte source idle
        start_stream();
        feed(8'h00, 1'b0); feed(8'h00, 1'b0); feed(8'h00, 1'b0);
        request(16'd16384);
        request(16'd32704);
        request(16'd32704);
        check("stall_cnt", 32'(OUT_CNT), 32'h37);
        in_prob = 16'd16384;
        in_req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("stall_req_rdy", 32'(in_req_ready), 32'd0);
            check("stall_no_pulse", 32'(OUT_BIT_VALID), 32'd0);
        end
        feed(8'h00, 1'b0); feed(8'h00, 1'b0); feed(8'h00, 1'b0);
        check("stall_resume_rdy", 32'(in_req_ready), 32'd1);
        check("stall_resume_cnt", 32'(OUT_CNT), 32'd15);
        tick();
        in_req_valid = 1'b0;
        check("stall_pulse", 32'(OUT_BIT_VALID), 32'd1);
        check("stall_bit", 32'(OUT_BIT), 32'd0);
        check("stall_rng", 32'(OUT_RANGE), 32'hADF8);
        check("stall_cnt2", 32'(OUT_CNT), 32'd14);

        // Async reset while stalled in REFILL
        start_stream();
        feed(8'h00, 1'b0); feed(8'h00, 1'b0); feed(8'h00, 1'b0);
        request(16'd16384);
        request(16'd32704);
        request(16'd32704);
        check("arst_in_refill", 32'(in_byte_ready), 32'd1);
        #3;
        top_reset = 1'b1;
        #1;
        check_reset_outputs("arst_now");
        tick();
        top_reset = 1'b0;
        in_byte_valid = 1'b1;
        in_req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("arst_idle_byte", 32'(in_byte_ready), 32'd0);
            check("arst_idle_req", 32'(in_req_ready), 32'd0);
            check("arst_idle_pulse", 32'(OUT_BIT_VALID), 32'd0);
        end
        in_byte_valid = 1'b0;
        in_req_valid = 1'b0;

        // Encoder model: od_ec boolean encode with carry resolution
        enc_low = 64'd0;
        enc_rng = 32'h8000;
        enc_cnt = -9;
        for (int i = 0; i < NBITS; i++) begin
            f = 16'($urandom_range(1, 32767));
            b = ($urandom_range(0, 32767) < 32'(f));
            probs_q.push_back(f);
            bits_q.push_back(b);
            v = (((enc_rng >> 8) * 32'(f >> 6)) >> 1) + 32'd4;
            if (b) enc_low = enc_low + 64'(enc_rng - v);
            r = b ? v : enc_rng - v;
            d = 15 - msb_of(r);
            c = enc_cnt;
            s = c + d;
            if (s >= 0) begin
                c = c + 16;
                m64 = (64'd1 << c) - 64'd1;
                if (s >= 8) begin
                    pre_q.push_back(32'(enc_low >> c));
                    enc_low = enc_low & m64;
                    c = c - 8;
                    m64 = m64 >> 8;
                end
                pre_q.push_back(32'(enc_low >> c));
                s = c + d - 24;
                enc_low = enc_low & m64;
            end
            enc_low = enc_low << d;
            enc_rng = r << d;
            enc_cnt = s;
        end
        m64 = 64'h3FFF;
        e64 = ((enc_low + m64) & ~m64) | (m64 + 64'd1);
        c = enc_cnt;
        s = 10 + c;
        if (s > 0) begin
            n64 = (64'd1 << (c + 16)) - 64'd1;
            do begin
                pre_q.push_back(32'(e64 >> (c + 16)));
                e64 = e64 & n64;
                s = s - 8;
                c = c - 8;
                n64 = n64 >> 8;
            end while (s > 0);
        end
        cy = 0;
        for (int k = pre_q.size() - 1; k >= 0; k--) begin
            cy = cy + pre_q[k];
            stream_q.push_front(cy[7:0]);
            cy = cy >> 8;
        end

        // Round trip with random byte gaps
        start_stream();
        bi = 0; ri = 0; oi = 0; cyc = 0;
        err_before = errors;
        while (oi < NBITS && cyc < 60000 && (errors - err_before) < 10) begin
            if (bi < stream_q.size() && $urandom_range(0, 3) != 0) begin
                in_byte_valid = 1'b1;
                in_byte = stream_q[bi];
                in_byte_last = (bi == stream_q.size() - 1);
            end else begin
                in_byte_valid = 1'b0;
                in_byte_last = 1'b0;
            end
            in_req_valid = (ri < NBITS);
            if (ri < NBITS) in_prob = probs_q[ri];
            byte_go = in_byte_valid && in_byte_ready;
            req_go = in_req_valid && in_req_ready;
            tick();
            cyc++;
            if (byte_go) bi++;
            if (req_go) ri++;
            if (OUT_BIT_VALID) begin
                check("rt_bit", 32'(OUT_BIT), 32'(bits_q[oi]));
                oi++;
            end
        end
        in_byte_valid = 1'b0;
        in_byte_last = 1'b0;
        in_req_valid = 1'b0;
        check("rt_done", 32'(oi), 32'(NBITS));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
